// File: rtl/store_commit_arbiter_if.sv
// Bundle of the arbiter's retire, SQ-head, load-unit, memory-port and status signals.
// The master modport is the arbiter's view; slave is the surrounding pipeline/memory view.
interface store_commit_arbiter_if #(
  parameter int SQ_SZ           = 8,
  parameter int NUM_SCALAR_BITS = 3
);
  localparam int CNT_W = $clog2(SQ_SZ + 1);

  logic [NUM_SCALAR_BITS-1:0] num_store_retiring;
  logic                       drain_mode;

  logic                       sq_head_valid;
  logic [31:0]                sq_head_addr;
  logic [31:0]                sq_head_data;
  logic [1:0]                 sq_head_size;
  logic                       sq_pop;

  logic                       ld_req_valid;
  logic [31:0]                ld_req_addr;
  logic [1:0]                 ld_req_size;
  logic                       ld_req_grant;
  logic                       ld_resp_valid;
  logic [31:0]                ld_resp_data;

  logic                       mem_req_valid;
  logic                       mem_req_store;
  logic [31:0]                mem_req_addr;
  logic [31:0]                mem_req_data;
  logic [1:0]                 mem_req_size;
  logic                       mem_req_ready;
  logic                       mem_resp_valid;
  logic [31:0]                mem_resp_data;

  logic [CNT_W-1:0]           committed_pending;
  logic                       stores_drained;
  logic                       overflow_err;

  modport master (
    input  num_store_retiring, drain_mode,
    input  sq_head_valid, sq_head_addr, sq_head_data, sq_head_size,
    output sq_pop,
    input  ld_req_valid, ld_req_addr, ld_req_size,
    output ld_req_grant, ld_resp_valid, ld_resp_data,
    output mem_req_valid, mem_req_store, mem_req_addr, mem_req_data, mem_req_size,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output committed_pending, stores_drained, overflow_err
  );

  modport slave (
    output num_store_retiring, drain_mode,
    output sq_head_valid, sq_head_addr, sq_head_data, sq_head_size,
    input  sq_pop,
    output ld_req_valid, ld_req_addr, ld_req_size,
    input  ld_req_grant, ld_resp_valid, ld_resp_data,
    input  mem_req_valid, mem_req_store, mem_req_addr, mem_req_data, mem_req_size,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  committed_pending, stores_drained, overflow_err
  );
endinterface

// File: rtl/store_commit_arbiter.sv
// Drains committed stores from the SQ head to the single memory port in order,
// sharing the port with load requests under an anti-starvation policy.
module store_commit_arbiter #(
  parameter int SQ_SZ           = 8,
  parameter int STARVE_LIMIT    = 4,
  parameter int NUM_SCALAR_BITS = 3
) (
  input logic                    clock,
  input logic                    reset,
  store_commit_arbiter_if.master bus
);
  localparam int CNT_W = $clog2(SQ_SZ + 1);
  localparam int SUM_W = CNT_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [2:0] {IDLE, ST_REQ, ST_WAIT, LD_REQ, LD_WAIT} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_pending;
  logic [SC_W-1:0]  r_starve_cnt;
  logic             r_overflow;
  logic             r_req_store;
  logic [31:0]      r_req_addr;
  logic [31:0]      r_req_data;
  logic [1:0]       r_req_size;

  logic             w_st_elig;
  logic             w_grant_st;
  logic             w_grant_ld;
  logic             w_sq_pop;
  logic             w_ld_resp_valid;
  logic [SUM_W-1:0] w_sum;
  logic             w_clamp;

  assign w_st_elig = (r_pending != '0) && bus.sq_head_valid;

  // Next-state and one-cycle pulses; arbitration is decided combinationally in IDLE.
  always_comb begin
    w_next          = r_state;
    w_grant_st      = 1'b0;
    w_grant_ld      = 1'b0;
    w_sq_pop        = 1'b0;
    w_ld_resp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_st_elig && (bus.drain_mode || (r_starve_cnt >= SC_W'(STARVE_LIMIT)) ||
                          !bus.ld_req_valid)) begin
          w_grant_st = 1'b1;
          w_next     = ST_REQ;
        end else if (bus.ld_req_valid && !bus.drain_mode) begin
          w_grant_ld = 1'b1;
          w_next     = LD_REQ;
        end
      end
      ST_REQ:  if (bus.mem_req_ready) w_next = ST_WAIT;
      ST_WAIT: if (bus.mem_resp_valid) begin
        w_sq_pop = 1'b1;
        w_next   = IDLE;
      end
      LD_REQ:  if (bus.mem_req_ready) w_next = LD_WAIT;
      LD_WAIT: if (bus.mem_resp_valid) begin
        w_ld_resp_valid = 1'b1;
        w_next          = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Committed-store count: add retires, subtract the pop, clamp at SQ depth and flag it.
  assign w_sum   = SUM_W'(r_pending) + SUM_W'(bus.num_store_retiring) - SUM_W'(w_sq_pop);
  assign w_clamp = w_sum > SUM_W'(SQ_SZ);

  // Pending counter and sticky overflow flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_pending <= w_clamp ? CNT_W'(SQ_SZ) : w_sum[CNT_W-1:0];
      if (w_clamp) r_overflow <= 1'b1;
    end
  end

  // Starvation counter: counts load grants taken while a store was eligible, saturating.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (w_grant_st) begin
      r_starve_cnt <= '0;
    end else if (w_grant_ld && w_st_elig && (r_starve_cnt < SC_W'(STARVE_LIMIT))) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  // Request fields captured at grant and held stable until the memory accepts them.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_req_store <= 1'b0;
      r_req_addr  <= '0;
      r_req_data  <= '0;
      r_req_size  <= '0;
    end else if (w_grant_st) begin
      r_req_store <= 1'b1;
      r_req_addr  <= bus.sq_head_addr;
      r_req_data  <= bus.sq_head_data;
      r_req_size  <= bus.sq_head_size;
    end else if (w_grant_ld) begin
      r_req_store <= 1'b0;
      r_req_addr  <= bus.ld_req_addr;
      r_req_data  <= '0;
      r_req_size  <= bus.ld_req_size;
    end
  end

  assign bus.mem_req_valid     = (r_state == ST_REQ) || (r_state == LD_REQ);
  assign bus.mem_req_store     = r_req_store;
  assign bus.mem_req_addr      = r_req_addr;
  assign bus.mem_req_data      = r_req_data;
  assign bus.mem_req_size      = r_req_size;
  assign bus.sq_pop            = w_sq_pop;
  assign bus.ld_req_grant      = w_grant_ld;
  assign bus.ld_resp_valid     = w_ld_resp_valid;
  assign bus.ld_resp_data      = w_ld_resp_valid ? bus.mem_resp_data : 32'h0;
  assign bus.committed_pending = r_pending;
  assign bus.stores_drained    = (r_pending == '0) && (r_state != ST_REQ) && (r_state != ST_WAIT);
  assign bus.overflow_err      = r_overflow;
endmodule

// File: tb/tb_store_commit_arbiter.sv
// Directed bench for store_commit_arbiter: store drain, load starvation limit,
// drain mode, retire/pop overlap, counter clamp and mid-transaction reset.
module tb_store_commit_arbiter;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  store_commit_arbiter_if #(.SQ_SZ(8), .NUM_SCALAR_BITS(3)) bus ();

  store_commit_arbiter #(.SQ_SZ(8), .STARVE_LIMIT(4), .NUM_SCALAR_BITS(3)) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered in the REQ cycle; accepts after one cycle, responds after one more, returns in IDLE.
  task automatic serve(input logic is_st, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic [31:0] rdata);
    #1;
    chk("req_valid", bus.mem_req_valid, 1);
    chk("req_store", bus.mem_req_store, is_st);
    chk("req_addr",  bus.mem_req_addr,  a);
    chk("req_data",  bus.mem_req_data,  d);
    chk("req_size",  bus.mem_req_size,  sz);
    bus.mem_req_ready = 1'b1;
    cyc();
    bus.mem_req_ready = 1'b0;
    chk("wait_req_valid", bus.mem_req_valid, 0);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = rdata;
    #1;
    chk("sq_pop",        bus.sq_pop,        is_st);
    chk("ld_resp_valid", bus.ld_resp_valid, !is_st);
    chk("ld_resp_data",  bus.ld_resp_data,  is_st ? 32'h0 : rdata);
    cyc();
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = 32'h0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.num_store_retiring = '0;
    bus.drain_mode     = 1'b0;
    bus.sq_head_valid  = 1'b0;
    bus.sq_head_addr   = 32'h0;
    bus.sq_head_data   = 32'h0;
    bus.sq_head_size   = 2'd0;
    bus.ld_req_valid   = 1'b0;
    bus.ld_req_addr    = 32'h0;
    bus.ld_req_size    = 2'd0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = 32'h0;
    cyc();
    cyc();
    #1;
    chk("rst_pending",  bus.committed_pending, 0);
    chk("rst_drained",  bus.stores_drained, 1);
    chk("rst_req_vld",  bus.mem_req_valid, 0);
    chk("rst_ovf",      bus.overflow_err, 0);
    chk("rst_req_addr", bus.mem_req_addr, 0);
    chk("rst_grant",    bus.ld_req_grant, 0);
    rst = 1'b0;

    // Two stores retire with no load traffic.
    bus.num_store_retiring = 3'd2;
    bus.sq_head_valid = 1'b1;
    bus.sq_head_addr  = 32'h100;
    bus.sq_head_data  = 32'hAAAA;
    bus.sq_head_size  = 2'd2;
    #1;
    chk("t1_pend0", bus.committed_pending, 0);
    cyc();
    bus.num_store_retiring = 3'd0;
    #1;
    chk("t1_pend2",    bus.committed_pending, 2);
    chk("t1_drained0", bus.stores_drained, 0);
    chk("t1_vld_T",    bus.mem_req_valid, 0);
    cyc();
    serve(1'b1, 32'h100, 32'hAAAA, 2'd2, 32'h0);
    bus.sq_head_addr = 32'h104;
    bus.sq_head_data = 32'hBBBB;
    #1;
    chk("t1_pend1", bus.committed_pending, 1);
    cyc();
    serve(1'b1, 32'h104, 32'hBBBB, 2'd2, 32'h0);
    bus.sq_head_valid = 1'b0;
    #1;
    chk("t1_pend_end", bus.committed_pending, 0);
    chk("t1_drained1", bus.stores_drained, 1);

    // Loads hold the port; one store commits alongside the first load grant.
    bus.ld_req_valid = 1'b1;
    bus.ld_req_addr  = 32'h200;
    bus.ld_req_size  = 2'd1;
    bus.num_store_retiring = 3'd1;
    bus.sq_head_valid = 1'b1;
    bus.sq_head_addr  = 32'h108;
    bus.sq_head_data  = 32'hCCCC;
    bus.sq_head_size  = 2'd2;
    #1;
    chk("t2_first_grant", bus.ld_req_grant, 1);
    cyc();
    bus.num_store_retiring = 3'd0;
    serve(1'b0, 32'h200, 32'h0, 2'd1, 32'h1234);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_starve_grant", bus.ld_req_grant, 1);
      cyc();
      serve(1'b0, 32'h200, 32'h0, 2'd1, 32'h1000 + i);
    end
    #1;
    chk("t2_store_wins", bus.ld_req_grant, 0);
    chk("t2_pend1",      bus.committed_pending, 1);
    cyc();
    serve(1'b1, 32'h108, 32'hCCCC, 2'd2, 32'h0);
    // Starvation count cleared: a newly waiting store yields to a load again.
    bus.sq_head_addr = 32'h10C;
    bus.sq_head_data = 32'hDDDD;
    bus.num_store_retiring = 3'd1;
    #1;
    chk("t2b_grant_a", bus.ld_req_grant, 1);
    cyc();
    bus.num_store_retiring = 3'd0;
    serve(1'b0, 32'h200, 32'h0, 2'd1, 32'h2222);
    #1;
    chk("t2b_grant_b", bus.ld_req_grant, 1);
    cyc();
    serve(1'b0, 32'h200, 32'h0, 2'd1, 32'h3333);
    bus.drain_mode = 1'b1;
    #1;
    chk("t2b_drain_block", bus.ld_req_grant, 0);
    cyc();
    serve(1'b1, 32'h10C, 32'hDDDD, 2'd2, 32'h0);

    // Drain mode with a load requesting and three pending stores.
    bus.num_store_retiring = 3'd3;
    bus.sq_head_addr = 32'h300;
    bus.sq_head_data = 32'h3000;
    #1;
    chk("t3_nogrant0", bus.ld_req_grant, 0);
    cyc();
    bus.num_store_retiring = 3'd0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t3_nogrant", bus.ld_req_grant, 0);
      chk("t3_pend",    bus.committed_pending, 3 - k);
      cyc();
      serve(1'b1, 32'h300 + 4 * k, 32'h3000 + k, 2'd2, 32'h0);
      bus.sq_head_addr = 32'h300 + 4 * (k + 1);
      bus.sq_head_data = 32'h3000 + k + 1;
    end
    bus.sq_head_valid = 1'b0;
    #1;
    chk("t3_pend0",     bus.committed_pending, 0);
    chk("t3_nogrant_e", bus.ld_req_grant, 0);
    bus.drain_mode = 1'b0;
    #1;
    chk("t3_grant_rel", bus.ld_req_grant, 1);
    cyc();
    serve(1'b0, 32'h200, 32'h0, 2'd1, 32'h5555);
    bus.ld_req_valid = 1'b0;

    // Retire coinciding with a pop keeps the count steady.
    bus.num_store_retiring = 3'd1;
    bus.sq_head_valid = 1'b1;
    bus.sq_head_addr  = 32'h400;
    bus.sq_head_data  = 32'h4444;
    bus.sq_head_size  = 2'd1;
    cyc();
    bus.num_store_retiring = 3'd0;
    cyc();
    #1;
    chk("t4_req_vld", bus.mem_req_valid, 1);
    chk("t4_req_st",  bus.mem_req_store, 1);
    bus.mem_req_ready = 1'b1;
    cyc();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.num_store_retiring = 3'd1;
    #1;
    chk("t4_pop", bus.sq_pop, 1);
    cyc();
    bus.mem_resp_valid = 1'b0;
    bus.num_store_retiring = 3'd0;
    bus.sq_head_addr = 32'h404;
    bus.sq_head_data = 32'h4445;
    #1;
    chk("t4_pend_hold", bus.committed_pending, 1);
    chk("t4_ovf0",      bus.overflow_err, 0);
    cyc();
    serve(1'b1, 32'h404, 32'h4445, 2'd1, 32'h0);
    bus.sq_head_valid = 1'b0;
    #1;
    chk("t4_pend0", bus.committed_pending, 0);

    // Fill to depth, then overflow.
    bus.num_store_retiring = 3'd7;
    cyc();
    bus.num_store_retiring = 3'd1;
    #1;
    chk("t5_pend7", bus.committed_pending, 7);
    cyc();
    bus.num_store_retiring = 3'd2;
    #1;
    chk("t5_pend8", bus.committed_pending, 8);
    chk("t5_ovf0",  bus.overflow_err, 0);
    cyc();
    bus.num_store_retiring = 3'd0;
    #1;
    chk("t5_clamp", bus.committed_pending, 8);
    chk("t5_ovf1",  bus.overflow_err, 1);
    cyc();
    #1;
    chk("t5_sticky", bus.overflow_err, 1);

    // Reset while waiting for a store acknowledge.
    bus.sq_head_valid = 1'b1;
    bus.sq_head_addr  = 32'h500;
    bus.sq_head_data  = 32'h5000;
    cyc();
    #1;
    chk("t6_req_vld", bus.mem_req_valid, 1);
    bus.mem_req_ready = 1'b1;
    cyc();
    bus.mem_req_ready = 1'b0;
    #1;
    chk("t6_wait_vld", bus.mem_req_valid, 0);
    chk("t6_wait_drn", bus.stores_drained, 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.sq_head_valid  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'hFFFF_FFFF;
    #1;
    chk("t6_vld0",     bus.mem_req_valid, 0);
    chk("t6_pend0",    bus.committed_pending, 0);
    chk("t6_ovf0",     bus.overflow_err, 0);
    chk("t6_drained",  bus.stores_drained, 1);
    chk("t6_no_pop",   bus.sq_pop, 0);
    chk("t6_no_resp",  bus.ld_resp_valid, 0);
    chk("t6_resp_dat", bus.ld_resp_data, 0);
    cyc();
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = 32'h0;
    #1;
    chk("t6_pend_after", bus.committed_pending, 0);
    chk("t6_vld_after",  bus.mem_req_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/store_commit_arbiter.md
# store_commit_arbiter

Sequences architecturally committed stores out of the store queue (SQ) to the single data-memory port and shares that port with the load unit. The retire stage reports how many stores commit each cycle; this block counts committed-but-unwritten stores, drains them in order from the SQ head, and arbitrates against load requests using an anti-starvation counter. It also reports when all committed stores have reached memory so the halt path can finish cleanly.

## Interface
Parameters:
- `SQ_SZ`, 8: SQ depth; `CNT_W = $clog2(SQ_SZ+1)`.
- `STARVE_LIMIT`, 4: consecutive load grants allowed while a committed store is waiting.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clock` in 1: clock.
  - `reset` in 1: synchronous, active-high.
- Retire and halt inputs:
  - `num_store_retiring` in `NUM_SCALAR_BITS`: stores committing this cycle, from retire.
  - `drain_mode` in 1: halt retired; stores take absolute priority.
- SQ head:
  - `sq_head_valid` in 1: SQ head entry present.
  - `sq_head_addr` in 32: SQ head address.
  - `sq_head_data` in 32: SQ head data.
  - `sq_head_size` in 2: SQ head `MEM_SIZE`.
  - `sq_pop` out 1: one-cycle pulse that frees the SQ head.
- Load unit:
  - `ld_req_valid` in 1: load request.
  - `ld_req_addr` in 32: load address.
  - `ld_req_size` in 2: load size.
  - `ld_req_grant` out 1: one-cycle pulse; request accepted.
  - `ld_resp_valid` out 1: one-cycle pulse; load data returned.
  - `ld_resp_data` out 32: load response data.
- Memory port:
  - `mem_req_valid` out 1: request valid.
  - `mem_req_store` out 1: 1 = store, 0 = load.
  - `mem_req_addr` out 32: request address.
  - `mem_req_data` out 32: store data.
  - `mem_req_size` out 2: request size.
  - `mem_req_ready` in 1: request accepted.
  - `mem_resp_valid` in 1: response or store acknowledge.
  - `mem_resp_data` in 32: response data.
- Status:
  - `committed_pending` out `CNT_W`: committed stores not yet acknowledged.
  - `stores_drained` out 1: `committed_pending == 0` and FSM is not in a store state.
  - `overflow_err` out 1: sticky error flag.

## Operation
- Counter update: `pending_next = pending + num_store_retiring - sq_pop`.
  - Computed at `CNT_W+1` bits.
  - If the result exceeds `SQ_SZ`, it clamps to `SQ_SZ` and sets `overflow_err`.
  - Retire and pop in the same cycle both apply.
- Store eligibility: `st_elig = (pending != 0) && sq_head_valid`.
- FSM states: IDLE, ST_REQ, ST_WAIT, LD_REQ, LD_WAIT.
- IDLE arbitration, in priority order:
  1. `st_elig && (drain_mode || starve_cnt >= STARVE_LIMIT || !ld_req_valid)`: grant store. Capture the head addr/data/size, go to ST_REQ, clear `starve_cnt`.
  2. Else if `ld_req_valid && !drain_mode`: pulse `ld_req_grant`, capture the load addr/size, go to LD_REQ. If `st_elig`, `starve_cnt++` (saturating at `STARVE_LIMIT`).
  3. Else stay in IDLE.
- ST_REQ / LD_REQ:
  - `mem_req_valid = 1` with the captured fields; fields are stable until accepted.
  - On `mem_req_ready`, go to ST_WAIT / LD_WAIT.
- ST_WAIT: on `mem_resp_valid`, pulse `sq_pop` and go to IDLE.
- LD_WAIT: on `mem_resp_valid`, pulse `ld_resp_valid` with `ld_resp_data = mem_resp_data` and go to IDLE.
- `mem_resp_valid` outside a WAIT state is ignored.
- Stores issue strictly in SQ order, at most one transaction outstanding.
- A load requester must hold `ld_req_*` stable until it sees grant.
- Output reset values:
  - `pending = 0`, `starve_cnt = 0`, `overflow_err = 0`, FSM = IDLE.
  - All pulses and `mem_req_valid` = 0.
  - `stores_drained = 1`; data outputs = 0.
- Reset mid-transaction drops the outstanding request; the memory side is reset concurrently.

## Timing
- Arbitration decision and `ld_req_grant` are combinational in the IDLE cycle (call it T).
- `mem_req_valid` is registered and rises at T+1.
- Best-case store: grant at T, ready at T+1, response at T+2, so `sq_pop` and the counter decrement take effect at T+2. Earliest next grant is T+3.
- Best-case load: grant at T, `ld_resp_valid` at T+2.
- Counting:
  - `committed_pending` reflects retires from cycle t at t+1.
  - A store retired at t is eligible for grant at t+1.
- `stores_drained` is registered-state derived, so there is no combinational path from `num_store_retiring`.
- With `drain_mode` high, no new load grant is issued; an in-flight load completes normally.

## Test plan
- Reset, then retire 2 stores with the head valid and no loads:
  - Grant at +1; `mem_req_valid` with `mem_req_store=1` at +2.
  - With ready and response each after 1 cycle, `sq_pop` pulses twice.
  - `committed_pending` goes 2→1→0 and `stores_drained` returns to 1.
- Continuous `ld_req_valid` plus 1 pending store, `STARVE_LIMIT=4`: exactly 4 load grants, then the store wins; `starve_cnt` clears.
- `drain_mode=1` with a load requesting and 3 pending stores: 3 store transactions and no `ld_req_grant` until `pending == 0`.
- Retire 1 store in the same cycle as `sq_pop` with `pending=1`: `pending` stays 1 and `overflow_err` stays 0.
- `pending=SQ_SZ` and retire 2 more: `pending` clamps at 8 and `overflow_err` is set and sticky until reset.
- Reset asserted in ST_WAIT: next cycle FSM is IDLE, `mem_req_valid=0`, `committed_pending=0`, and a late `mem_resp_valid` produces no `sq_pop`.
